fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; these are taken from the FIFO read data.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; values below 2 are illegal.
REQ-003 Parameter PARITY_EN, default 0; 1 inserts one parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0; 0 gives even parity, 1 gives odd parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset; 0 resets immediately, independent of clk.
REQ-007 en_i  input  1  transmit enable; gates new FIFO fetches only.
REQ-008 fifo_empty_i  input  1  empty flag of the upstream synchronous FIFO.
REQ-009 fifo_wr_en_i  input  1  copy of the FIFO's write enable; the FIFO gives write priority over read in the same cycle.
REQ-010 fifo_rdata_i  input  WIDTH  registered FIFO read data, valid the cycle after a granted read.
REQ-011 fifo_rd_en_o  output  1  FIFO read strobe.
REQ-012 tx_o  output  1  serial line; idles high.
REQ-013 busy_o  output  1  high from fetch until the stop bit completes.
REQ-014 frame_done_o  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, START, DATA, PARITY and STOP.
REQ-016 fifo_rd_en_o SHALL be combinational and equal to (state==IDLE & en_i & ~fifo_empty_i & ~fifo_wr_en_i); it is never high outside IDLE.
REQ-017 IDLE SHALL go to LOAD on any cycle where fifo_rd_en_o=1; otherwise IDLE SHALL hold.
REQ-018 The LOAD state SHALL last one cycle:
- it latches fifo_rdata_i into the shift register;
- it drives tx_o low at its closing edge;
- it then goes to START.
REQ-019 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles. The bit counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
REQ-020 DATA SHALL shift out WIDTH bits LSB first, using a bit index of $clog2(WIDTH+1) bits. After the last bit the state goes to PARITY if PARITY_EN=1, else to STOP.
REQ-021 The parity bit SHALL be the XOR of the latched data bits, inverted when PARITY_ODD=1.
REQ-022 STOP SHALL drive tx_o=1. On its final cycle it SHALL assert frame_done_o for that one cycle and return to IDLE.
REQ-023 tx_o SHALL be registered and glitch-free.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 Back-to-back frames SHALL have exactly 2 idle-high cycles between the end of STOP and the next start bit (IDLE cycle plus LOAD cycle).
REQ-026 Dropping en_i mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-027 Changes on fifo_empty_i or fifo_wr_en_i outside IDLE SHALL be ignored.
REQ-028 Exactly one FIFO read SHALL be issued per transmitted frame.

Reset
REQ-029 While rst=0, the block SHALL hold state=IDLE, tx_o=1, busy_o=0, frame_done_o=0 and fifo_rd_en_o=0, and clear the shift register and all counters to 0.
REQ-030 Reset mid-frame SHALL abort the frame immediately (tx_o high asynchronously); the aborted byte is discarded, not re-fetched.
REQ-031 After rst rises, the first fetch SHALL be possible on the first clk edge, subject to REQ-016.

Verification (CLKS_PER_BIT=4, WIDTH=8 unless stated)
REQ-032 Single byte: FIFO holds 0xA5, en_i=1.
- fifo_rd_en_o pulses for 1 cycle.
- tx_o carries 0,1,0,1,0,0,1,0,1,1, each for 4 clocks.
- frame_done_o pulses once; busy_o is high for 1+40 cycles.
REQ-033 Back-to-back: FIFO holds 0x00 then 0xFF. Two frames are sent, with exactly 2 high cycles between the first stop bit and the second start bit, and two rd_en pulses.
REQ-034 Parity: PARITY_EN=1, data 0x07. Even parity gives parity bit 1; PARITY_ODD=1 gives 0. The frame is 11 bits, 44 clocks.
REQ-035 Write collision: fifo_empty_i=0 with fifo_wr_en_i=1 for 3 cycles. fifo_rd_en_o stays 0 during those cycles and asserts on the first cycle after fifo_wr_en_i falls.
REQ-036 Reset mid-frame: rst=0 during data bit 3. tx_o=1 and busy_o=0 with no clock edge. After release with FIFO non-empty, a new fetch occurs on the first edge.
REQ-037 Enable gating: en_i=0 with FIFO non-empty gives no rd_en for 20 cycles. Dropping en_i during START completes that frame, then the block idles.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if -- read-side handshake between an upstream synchronous FIFO
// and the UART transmitter.
//   fifo_empty_i  FIFO empty flag
//   fifo_wr_en_i  copy of the FIFO write enable (write wins over read)
//   fifo_rdata_i  registered read data, valid the cycle after a granted read
//   fifo_rd_en_o  read strobe from the transmitter
// Modports: master = transmitter side, slave = FIFO side.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty_i;
    logic             fifo_wr_en_i;
    logic [WIDTH-1:0] fifo_rdata_i;
    logic             fifo_rd_en_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_wr_en_i,
        input  fifo_rdata_i,
        output fifo_rd_en_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_wr_en_i,
        output fifo_rdata_i,
        input  fifo_rd_en_o
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- fetches words from a synchronous FIFO and sends each one as
// a serial frame: start bit, WIDTH data bits LSB first, optional parity bit,
// stop bit. Every bit lasts CLKS_PER_BIT clocks (CLKS_PER_BIT must be >= 2).
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-low reset
//   en_i          transmit enable; only gates new fetches
//   fifo          FIFO read handshake (fifo_uart_tx_if.master)
//   tx_o          registered serial line, idles high
//   busy_o        high in every state except IDLE
//   frame_done_o  one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    fifo_uart_tx_if.master fifo,
    output logic           tx_o,
    output logic           busy_o,
    output logic           frame_done_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nx;
    logic [IDX_W-1:0] r_idx,   w_idx_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic             r_par,   w_par_nx;
    logic             r_tx,    w_tx_nx;
    logic             w_bit_end;
    logic             w_rd_en;

    // A read is only issued when the FIFO cannot be mid-write, so the
    // FIFO's write priority never silently swallows our strobe. Gating with
    // rst keeps the strobe low while reset is held.
    assign w_rd_en = rst & (r_state == S_IDLE) & en_i
                   & ~fifo.fifo_empty_i & ~fifo.fifo_wr_en_i;

    assign fifo.fifo_rd_en_o = w_rd_en;
    assign w_bit_end         = (r_cnt == CNT_LAST);
    assign tx_o              = r_tx;
    assign busy_o            = (r_state != S_IDLE);
    assign frame_done_o      = (r_state == S_STOP) & w_bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_tx    <= w_tx_nx;
        end
    end

    // tx is computed one cycle ahead so the line changes exactly on the edge
    // that enters each bit period.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_tx_nx    = r_tx;

        if (r_state != S_IDLE && r_state != S_LOAD)
            w_cnt_nx = w_bit_end ? '0 : r_cnt + CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                if (w_rd_en) w_state_nx = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nx = fifo.fifo_rdata_i;
                w_par_nx   = (^fifo.fifo_rdata_i) ^ ODD_BIT;
                w_tx_nx    = 1'b0;
                w_cnt_nx   = '0;
                w_state_nx = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_tx_nx    = r_shift[0];
                    w_shift_nx = r_shift >> 1;
                    w_idx_nx   = '0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_tx_nx    = r_par;
                            w_state_nx = S_PARITY;
                        end else begin
                            w_tx_nx    = 1'b1;
                            w_state_nx = S_STOP;
                        end
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_tx_nx    = r_shift[0];
                        w_shift_nx = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_nx    = 1'b1;
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) w_state_nx = S_IDLE;
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = S_IDLE;
            end
        endcase
    end
endmodule
